// File: rtl/bcd_seq_converter.sv
// Iterative double-dabble binary-to-BCD converter with start/busy/done handshake.
// Optional macro ZERO_BLANK_EN adds a registered leading-zero blank mask output.
module bcd_seq_converter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      inNum,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  ovf
`ifdef ZERO_BLANK_EN
  , output logic [DIGITS-1:0]   blank
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BW = 4 * DIGITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] bin_sr_q, bin_sr_d;
  logic [BW-1:0]    bcd_acc_q, bcd_acc_d;
  logic [BW-1:0]    digits_q, digits_d;
  logic             ovf_q, ovf_d;
  logic             ovf_next_q, ovf_next_d;

  logic [BW-1:0]    adj;
  logic [BW-1:0]    shifted;

  // Add-3 correction on every nibble that would reach 10 or more after doubling.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (bcd_acc_q[4*gi +: 4] >= 4'd5) ?
                              bcd_acc_q[4*gi +: 4] + 4'd3 : bcd_acc_q[4*gi +: 4];
    end
  endgenerate

  // The carry out of the top nibble is dropped, giving the value modulo 10^DIGITS.
  assign shifted = (adj << 1) | BW'(bin_sr_q[WIDTH-1]);

`ifdef ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d, blank_calc;

  assign blank_calc[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
      assign blank_calc[gi] = ~|shifted[BW-1:4*gi];
    end
  endgenerate
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_sr_d   = bin_sr_q;
    bcd_acc_d  = bcd_acc_q;
    digits_d   = digits_q;
    ovf_d      = ovf_q;
    ovf_next_d = ovf_next_q;
`ifdef ZERO_BLANK_EN
    blank_d    = blank_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_sr_d   = inNum;
          bcd_acc_d  = '0;
          cnt_d      = '0;
          ovf_next_d = (64'(inNum) >= LIMIT);
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bcd_acc_d = shifted;
        bin_sr_d  = bin_sr_q << 1;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          digits_d = shifted;
          ovf_d    = ovf_next_q;
`ifdef ZERO_BLANK_EN
          blank_d  = blank_calc;
`endif
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bin_sr_q   <= '0;
      bcd_acc_q  <= '0;
      digits_q   <= '0;
      ovf_q      <= 1'b0;
      ovf_next_q <= 1'b0;
`ifdef ZERO_BLANK_EN
      blank_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_sr_q   <= bin_sr_d;
      bcd_acc_q  <= bcd_acc_d;
      digits_q   <= digits_d;
      ovf_q      <= ovf_d;
      ovf_next_q <= ovf_next_d;
`ifdef ZERO_BLANK_EN
      blank_q    <= blank_d;
`endif
    end
  end

  assign busy   = (state_q == S_SHIFT);
  assign done   = (state_q == S_DONE);
  assign digits = digits_q;
  assign ovf    = ovf_q;
`ifdef ZERO_BLANK_EN
  assign blank  = blank_q;
`endif

endmodule
